decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
// ID stage of the 5-stage pipeline, directly downstream of IF. Latches IF's instruction, PC and double-word flags into
// the IF/ID register, reads the 16x32 register file with forwarding, resolves branches/JR/J/CLL and drives IF's
// pc_src/targets/kill/call. Detects load-use hazards (stall) and launches a registered ID/EX bundle toward EX.
// PARAMETERS
// N        32  datapath / PC width
// REGS     16  register count (4-bit specifiers)
// LINK_REG 14  register written with pc+1 by CLL
// PORTS
// clk          in   1   pipeline clock
// clear        in   1   reset; one clock; reset is asynchronous and active-low
// inst_in      in   32  instruction from IF (already zeroed by IF when killed)
// pc_in        in   32  PC of inst_in (IF pc_buff_tun)
// add_rd_in    in   1   double-word second half: use rd+1
// add_imm_in   in   1   double-word second half: use imm+1
// wb_en        in   1   writeback enable
// wb_rd        in   4   writeback register
// wb_data      in   32  writeback value
// ex_wen       in   1   EX instruction writes a register
// ex_is_load   in   1   EX instruction is LW/LDW
// ex_rd        in   4   EX destination
// ex_result    in   32  EX ALU result (forward source)
// mem_wen      in   1   MEM instruction writes a register
// mem_rd       in   4   MEM destination
// mem_result   in   32  MEM result incl. load data (forward source)
// stall        out  1   to IF: hold PC and IF buffers
// kill         out  1   to IF: zero the fetched instruction
// call         out  1   to IF: current ID instruction is CLL
// pc_src       out  2   0 pc+1, 1 branch, 2 jr, 3 jump
// branch       out  32  pc + sext(imm14)
// jr           out  32  forwarded rs1 value
// jump         out  32  pc + sext(inst[25:0])
// idex_valid   out  1   ID/EX bundle valid
// idex_op      out  6   opcode
// idex_rd      out  4   destination (rd, +1 if add_rd)
// idex_a       out  32  forwarded rs1 value
// idex_b       out  32  forwarded rs2 value (store data for SW/SDW = forwarded rd)
// idex_imm     out  32  sext(imm14), +1 if add_imm
// idex_wen     out  1   instruction writes a register
// BEHAVIOUR
// - Fields: op[31:26], rd[25:22], rs1[21:18], rs2[17:14], imm14[13:0]. Opcodes: 0-3 R-type, 5 ADDI, 6 LW, 7 SW,
//   8 LDW, 9 SDW, 10 BZ, 11 BGZ, 12 BLZ, 13 JR, 14 J, 15 CLL. inst==0 is NOP (idex_wen=0).
// - Reset (clear=0, async): IF/ID regs, all idex_* and every RF entry = 0; stall/kill/call=0, pc_src=0.
// - IF/ID register loads each posedge unless stall=1 (holds). ID/EX registers load every posedge: 1-cycle latency.
// - Forward priority per source: EX (ex_wen & ex_rd match) > MEM > RF. RF is write-first: same-cycle wb_rd read
//   returns wb_data. Registers 0..15 all writable.
// - stall = ex_wen & ex_is_load & (ex_rd matches any register the ID instruction reads). While stall: ID/EX loads a
//   bubble (valid=0, wen=0), pc_src=0, kill=0, call=0. Next cycle same instruction re-evaluates with MEM forwarding.
// - Branch in ID: BZ rs1==0, BGZ signed >0, BLZ signed <0. Taken branch/JR/J/CLL (not stalled): pc_src set, kill=1
//   same cycle; the wrong-path fetch enters IF/ID as 0.
// - CLL: pc_src=3, call=1, writes pc_in+1 into LINK_REG via ID/EX (idex_rd=LINK_REG, wen=1, a=pc_in+1).
// - Double-word: rd+1 and imm+1 wrap modulo 16 / 2^32; simultaneous add_rd/add_imm allowed.
// - Arithmetic: targets are 32-bit two's-complement adds, overflow discarded.
// - Simultaneous wb_en and RF read of the same register: write-first value. wb_en with clear=0: ignored.
// - Reset mid-stall: everything clears; no stall persists after clear deasserts.
// STRUCTURE
// - Shared include isa_defs.vh: opcode localparams, field bit positions, PC_SRC_* encodings.
// - Sub-module reg_file (16x32, one write, three combinational reads, write-first, async active-low clear).
// - Top holds the IF/ID register, forwarding muxes, hazard/branch logic and ID/EX register.
// TESTING
// - ADDI R1,R1,5 (0x14440005) then ADDI R2,R1,1 -> 2nd idex_a=5 via EX forward, no stall.
// - LW R6,R0,0 in EX, next CMP reads R6 -> stall=1 one cycle, bubble out, then idex_b=mem_result.
// - BGZ R2,-4 at pc=42, R2=3 -> pc_src=1, branch=38, kill=1; R2=0 -> pc_src=0, kill=0.
// - CLL 0x3C000010 at pc=0 -> pc_src=3, jump=16, call=1; R14=1 after writeback; JR R14 -> pc_src=2, jr=1.
// - LDW second half (add_rd=1, add_imm=1) rd=15, imm=0x3FFF -> idex_rd=0, idex_imm=0.
// - clear=0 during a stall cycle -> all outputs 0 asynchronously; first instruction after release passes normally.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the ID stage: opcodes, PC-select codes,
// inter-stage bundles and immediate helpers.
package decode_stage_pkg;

    localparam int N        = 32;
    localparam int REGS     = 16;
    localparam int LINK_REG = 14;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RD_MSB   = 25;
    localparam int RD_LSB   = 22;
    localparam int RS1_MSB  = 21;
    localparam int RS1_LSB  = 18;
    localparam int RS2_MSB  = 17;
    localparam int RS2_LSB  = 14;
    localparam int IMM_MSB  = 13;

    localparam logic [5:0] OP_R0   = 6'd0;
    localparam logic [5:0] OP_R3   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_LDW  = 6'd8;
    localparam logic [5:0] OP_SDW  = 6'd9;
    localparam logic [5:0] OP_BZ   = 6'd10;
    localparam logic [5:0] OP_BGZ  = 6'd11;
    localparam logic [5:0] OP_BLZ  = 6'd12;
    localparam logic [5:0] OP_JR   = 6'd13;
    localparam logic [5:0] OP_J    = 6'd14;
    localparam logic [5:0] OP_CLL  = 6'd15;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JR  = 2'd2;
    localparam logic [1:0] PC_SRC_JMP = 2'd3;

    typedef struct packed {
        logic [N-1:0] inst;
        logic [N-1:0] pc;
        logic         add_rd;
        logic         add_imm;
    } if_id_t;

    typedef struct packed {
        logic         valid;
        logic [5:0]   op;
        logic [3:0]   rd;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] imm;
        logic         wen;
    } id_ex_t;

    function automatic logic [N-1:0] sext14(input logic [13:0] v);
        return {{(N-14){v[13]}}, v};
    endfunction

    function automatic logic [N-1:0] sext26(input logic [25:0] v);
        return {{(N-26){v[25]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 16x32 register file: one write port, three combinational read ports,
// write-first bypass, asynchronous active-low clear.
module decode_stage_reg_file
    import decode_stage_pkg::*;
(
    input  logic         clk,
    input  logic         clear,
    input  logic         we,
    input  logic [3:0]   wa,
    input  logic [N-1:0] wd,
    input  logic [3:0]   ra0,
    input  logic [3:0]   ra1,
    input  logic [3:0]   ra2,
    output logic [N-1:0] rd0,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2
);

    logic [N-1:0] mem [REGS];
    logic         byp;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // A write held off by clear must not leak through the bypass either.
    assign byp = we & clear;

    assign rd0 = (byp && wa == ra0) ? wd : mem[ra0];
    assign rd1 = (byp && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (byp && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, forwarded register reads, load-use stall,
// branch/jump resolution toward IF and the registered ID/EX bundle.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] inst_in,
    input  logic [N-1:0] pc_in,
    input  logic         add_rd_in,
    input  logic         add_imm_in,
    input  logic         wb_en,
    input  logic [3:0]   wb_rd,
    input  logic [N-1:0] wb_data,
    input  logic         ex_wen,
    input  logic         ex_is_load,
    input  logic [3:0]   ex_rd,
    input  logic [N-1:0] ex_result,
    input  logic         mem_wen,
    input  logic [3:0]   mem_rd,
    input  logic [N-1:0] mem_result,
    output logic         stall,
    output logic         kill,
    output logic         call,
    output logic [1:0]   pc_src,
    output logic [N-1:0] branch,
    output logic [N-1:0] jr,
    output logic [N-1:0] jump,
    output logic         idex_valid,
    output logic [5:0]   idex_op,
    output logic [3:0]   idex_rd,
    output logic [N-1:0] idex_a,
    output logic [N-1:0] idex_b,
    output logic [N-1:0] idex_imm,
    output logic         idex_wen
);

    if_id_t ifid;
    id_ex_t idex_d;
    id_ex_t idex_q;

    logic [5:0]   op;
    logic [3:0]   rd_eff;
    logic [3:0]   rs1;
    logic [3:0]   rs2;
    logic [N-1:0] imm_sx;
    logic [N-1:0] imm_eff;
    logic [N-1:0] rf_a;
    logic [N-1:0] rf_b;
    logic [N-1:0] rf_d;
    logic [N-1:0] a_val;
    logic [N-1:0] s2_val;
    logic [N-1:0] d_val;
    logic         is_nop;
    logic         use1;
    logic         use2;
    logic         use_rd;
    logic         writes;
    logic         is_store;
    logic         is_br;
    logic         is_jr;
    logic         is_jmp;
    logic         is_cll;
    logic         taken;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            ifid <= '0;
        end else if (!stall) begin
            ifid.inst    <= inst_in;
            ifid.pc      <= pc_in;
            ifid.add_rd  <= add_rd_in;
            ifid.add_imm <= add_imm_in;
        end
    end

    assign op      = ifid.inst[OP_MSB:OP_LSB];
    assign rs1     = ifid.inst[RS1_MSB:RS1_LSB];
    assign rs2     = ifid.inst[RS2_MSB:RS2_LSB];
    assign rd_eff  = ifid.inst[RD_MSB:RD_LSB] + {3'b0, ifid.add_rd};
    assign imm_sx  = sext14(ifid.inst[IMM_MSB:0]);
    assign imm_eff = imm_sx + {{(N-1){1'b0}}, ifid.add_imm};
    assign is_nop  = (ifid.inst == '0);

    always_comb begin
        use1     = 1'b0;
        use2     = 1'b0;
        use_rd   = 1'b0;
        writes   = 1'b0;
        is_store = 1'b0;
        is_br    = 1'b0;
        is_jr    = 1'b0;
        is_jmp   = 1'b0;
        is_cll   = 1'b0;
        if (!is_nop) begin
            unique case (1'b1)
                (op >= OP_R0 && op <= OP_R3): begin
                    use1   = 1'b1;
                    use2   = 1'b1;
                    writes = 1'b1;
                end
                (op == OP_ADDI || op == OP_LW || op == OP_LDW): begin
                    use1   = 1'b1;
                    writes = 1'b1;
                end
                (op == OP_SW || op == OP_SDW): begin
                    use1     = 1'b1;
                    use_rd   = 1'b1;
                    is_store = 1'b1;
                end
                (op >= OP_BZ && op <= OP_BLZ): begin
                    use1  = 1'b1;
                    is_br = 1'b1;
                end
                (op == OP_JR): begin
                    use1  = 1'b1;
                    is_jr = 1'b1;
                end
                (op == OP_J): is_jmp = 1'b1;
                (op == OP_CLL): begin
                    is_cll = 1'b1;
                    writes = 1'b1;
                end
                default: ;
            endcase
        end
    end

    decode_stage_reg_file u_rf (
        .clk   (clk),
        .clear (clear),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data),
        .ra0   (rs1),
        .ra1   (rs2),
        .ra2   (rd_eff),
        .rd0   (rf_a),
        .rd1   (rf_b),
        .rd2   (rf_d)
    );

    assign a_val  = (ex_wen && ex_rd == rs1) ? ex_result :
                    (mem_wen && mem_rd == rs1) ? mem_result : rf_a;
    assign s2_val = (ex_wen && ex_rd == rs2) ? ex_result :
                    (mem_wen && mem_rd == rs2) ? mem_result : rf_b;
    assign d_val  = (ex_wen && ex_rd == rd_eff) ? ex_result :
                    (mem_wen && mem_rd == rd_eff) ? mem_result : rf_d;

    // A load in EX has no data yet; hold ID until it reaches MEM.
    assign stall = ex_wen & ex_is_load &
                   ((use1 & (ex_rd == rs1)) |
                    (use2 & (ex_rd == rs2)) |
                    (use_rd & (ex_rd == rd_eff)));

    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_BZ:   taken = (a_val == '0);
            OP_BGZ:  taken = !a_val[N-1] && (a_val != '0);
            OP_BLZ:  taken = a_val[N-1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_src = PC_SRC_SEQ;
        if (!stall) begin
            unique case (1'b1)
                (is_br && taken):   pc_src = PC_SRC_BR;
                is_jr:              pc_src = PC_SRC_JR;
                (is_jmp || is_cll): pc_src = PC_SRC_JMP;
                default:            pc_src = PC_SRC_SEQ;
            endcase
        end
    end

    assign kill   = (pc_src != PC_SRC_SEQ);
    assign call   = is_cll & ~stall;
    assign branch = ifid.pc + imm_sx;
    assign jump   = ifid.pc + sext26(ifid.inst[RD_MSB:0]);
    assign jr     = a_val;

    always_comb begin
        idex_d = '0;
        if (!stall && !is_nop) begin
            idex_d.valid = 1'b1;
            idex_d.op    = op;
            idex_d.rd    = is_cll ? 4'(LINK_REG) : rd_eff;
            idex_d.a     = is_cll ? ifid.pc + 1 : a_val;
            idex_d.b     = is_store ? d_val : s2_val;
            idex_d.imm   = imm_eff;
            idex_d.wen   = writes;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex_valid = idex_q.valid;
    assign idex_op    = idex_q.op;
    assign idex_rd    = idex_q.rd;
    assign idex_a     = idex_q.a;
    assign idex_b     = idex_q.b;
    assign idex_imm   = idex_q.imm;
    assign idex_wen   = idex_q.wen;

endmodule
